// File: rtl/uart_pkg.sv
// Shared constants for the UART FIFO bridge: register map, STATUS/CTRL bit
// positions and the value returned when DATA is read from an empty RX FIFO.
package uart_pkg;

  localparam logic [1:0] UART_ADDR_DATA   = 2'd0;
  localparam logic [1:0] UART_ADDR_STATUS = 2'd1;
  localparam logic [1:0] UART_ADDR_CTRL   = 2'd2;

  localparam int STAT_OVERRUN   = 16;
  localparam int STAT_RXCNT_LSB = 8;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  localparam logic [31:0] UART_EMPTY_READ = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_fifo_bridge_byte_fifo.sv
// Synchronous byte FIFO with async reset. A pop frees the slot a same-cycle
// push needs, so push+pop on a full FIFO both succeed.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [7:0]               head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign empty_o   = (count_q == (AW+1)'(0));
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU-side bridge between a UART byte interface and a word-wide register port.
// Optional interrupt logic and CTRL register are enabled by UART_FIFO_IRQ_EN.
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        rx_complete,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_complete
`ifdef UART_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  logic [TAW:0] tx_count_s, tx_free_s;
  logic [RAW:0] rx_count_s;
  logic         tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [7:0]   rx_head_s;
  logic         data_wr_s, data_rd_s, status_wr_s, rx_pop_s;
  logic         overrun_q, overrun_d;
  logic [31:0]  rdata_d;
  logic [31:0]  ctrl_rd_s;
  logic         unused_ok_s;

  assign data_wr_s   = cpu_valid & cpu_write & (cpu_addr == UART_ADDR_DATA);
  assign data_rd_s   = cpu_valid & ~cpu_write & (cpu_addr == UART_ADDR_DATA);
  assign status_wr_s = cpu_valid & cpu_write & (cpu_addr == UART_ADDR_STATUS);
  assign rx_pop_s    = data_rd_s & ~rx_empty_s;
  assign tx_free_s   = (TAW+1)'(TX_DEPTH) - tx_count_s;
  assign tx_valid    = ~tx_empty_s;
  assign unused_ok_s = ^{cpu_wdata[31:17], cpu_wdata[15:8], tx_full_s};

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (data_wr_s),
    .pop_i   (tx_complete),
    .din_i   (cpu_wdata[7:0]),
    .full_o  (tx_full_s),
    .empty_o (tx_empty_s),
    .count_o (tx_count_s),
    .head_o  (tx_data)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rx_complete),
    .pop_i   (rx_pop_s),
    .din_i   (rx_data),
    .full_o  (rx_full_s),
    .empty_o (rx_empty_s),
    .count_o (rx_count_s),
    .head_o  (rx_head_s)
  );

`ifdef UART_FIFO_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  assign ctrl_rd_s = {30'h0, ctrl_q};
  assign irq       = irq_q;

  // CTRL write decode and interrupt cause evaluation.
  always_comb begin
    ctrl_d = ctrl_q;
    if (cpu_valid & cpu_write & (cpu_addr == UART_ADDR_CTRL)) begin
      ctrl_d = cpu_wdata[1:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    irq_d = (ctrl_q[CTRL_RX_IE] & ~rx_empty_s) | (ctrl_q[CTRL_TX_IE] & tx_empty_s);
  end

  // CTRL and interrupt registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end
`else
  assign ctrl_rd_s = 32'h0;
`endif

  // Sticky overrun flag and registered read mux.
  always_comb begin
    overrun_d = overrun_q;
    rdata_d   = 32'h0;
    // A drop in the same cycle as a clear must remain visible.
    if (rx_complete & rx_full_s & ~rx_pop_s) begin
      overrun_d = 1'b1;
    end else if (status_wr_s & cpu_wdata[STAT_OVERRUN]) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (cpu_valid & ~cpu_write) begin
      case (cpu_addr)
        UART_ADDR_DATA:   rdata_d = rx_empty_s ? UART_EMPTY_READ : {24'h0, rx_head_s};
        UART_ADDR_STATUS: rdata_d = {15'h0, overrun_q, 8'(rx_count_s), 8'(tx_free_s)};
        UART_ADDR_CTRL:   rdata_d = ctrl_rd_s;
        default:          rdata_d = 32'h0;
      endcase
    end else begin
      rdata_d = 32'h0;
    end
  end

  // Bus response and overrun registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 32'h0;
    end else begin
      overrun_q <= overrun_d;
      cpu_ack   <= cpu_valid;
      cpu_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed self-checking bench for uart_fifo_bridge (default depths 16).
// Interrupt checks are compiled in when UART_FIFO_IRQ_EN is defined.
module tb_uart_fifo_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_valid = 1'b0;
  logic        cpu_write = 1'b0;
  logic [1:0]  cpu_addr = 2'd0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        rx_complete = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_complete = 1'b0;
`ifdef UART_FIFO_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  always #5 clock = ~clock;

  uart_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_valid   (cpu_valid),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .rx_complete (rx_complete),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_complete (tx_complete)
`ifdef UART_FIFO_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock);
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clock);
    cpu_valid = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clock);
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = a;
    @(negedge clock);
    cpu_valid = 1'b0;
    check("read_ack", {31'h0, cpu_ack}, 32'h1);
    d = cpu_rdata;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clock);
    rx_complete = 1'b1; rx_data = b;
    @(negedge clock);
    rx_complete = 1'b0;
  endtask

  task automatic tx_done();
    @(negedge clock);
    tx_complete = 1'b1;
    @(negedge clock);
    tx_complete = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_ack", {31'h0, cpu_ack}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    bus_read(2'd1, rd);
    check("rst_status", rd, 32'h0000_0010);

    // 1. TX path
    bus_write(2'd0, 32'h41);
    bus_write(2'd0, 32'h42);
    check("tx_valid_1", {31'h0, tx_valid}, 32'h1);
    check("tx_data_41", {24'h0, tx_data}, 32'h41);
    bus_read(2'd1, rd);
    check("tx_free_14", rd, 32'h0000_000E);
    tx_done();
    check("tx_valid_2", {31'h0, tx_valid}, 32'h1);
    check("tx_data_42", {24'h0, tx_data}, 32'h42);
    tx_done();
    check("tx_valid_0", {31'h0, tx_valid}, 32'h0);
    tx_done();
    bus_read(2'd1, rd);
    check("tx_empty_pop", rd, 32'h0000_0010);

    // 2. RX path
    rx_byte(8'h10); rx_byte(8'h20); rx_byte(8'h30);
    bus_read(2'd1, rd);
    check("rx_count_3", rd, 32'h0000_0310);
    bus_read(2'd0, rd); check("rx_rd_10", rd, 32'h10);
    bus_read(2'd0, rd); check("rx_rd_20", rd, 32'h20);
    bus_read(2'd0, rd); check("rx_rd_30", rd, 32'h30);
    bus_read(2'd0, rd); check("rx_rd_empty", rd, 32'hFFFF_FFFF);

    // 3. Overrun
    for (int i = 0; i < 17; i++) rx_byte(8'h50 + 8'(i));
    bus_read(2'd1, rd);
    check("ovr_status", rd, 32'h0001_1010);
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, rd);
      check("ovr_data", rd, 32'h50 + 32'(i));
    end
    bus_read(2'd0, rd); check("ovr_drained", rd, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check("ovr_sticky", rd, 32'h0001_0010);
    bus_write(2'd1, 32'h0000_FFFF);
    bus_read(2'd1, rd); check("ovr_noclear", rd, 32'h0001_0010);
    bus_write(2'd1, 32'h0001_0000);
    bus_read(2'd1, rd); check("ovr_clear", rd, 32'h0000_0010);

    // 4. Full RX, pop and push in the same cycle
    for (int i = 0; i < 16; i++) rx_byte(8'h60 + 8'(i));
    @(negedge clock);
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 2'd0;
    rx_complete = 1'b1; rx_data = 8'h99;
    @(negedge clock);
    cpu_valid = 1'b0; rx_complete = 1'b0;
    check("pp_ack", {31'h0, cpu_ack}, 32'h1);
    check("pp_data", cpu_rdata, 32'h60);
    bus_read(2'd1, rd);
    check("pp_status", rd, 32'h0000_1010);
    for (int i = 1; i < 16; i++) begin
      bus_read(2'd0, rd);
      check("pp_drain", rd, 32'h60 + 32'(i));
    end
    bus_read(2'd0, rd); check("pp_last_99", rd, 32'h99);
    bus_read(2'd0, rd); check("pp_empty", rd, 32'hFFFF_FFFF);

    // 5. Reset mid-frame with a bus response in flight
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'hA0 + 32'(i));
    check("mf_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("mf_tx_data", {24'h0, tx_data}, 32'hA0);
    @(negedge clock);
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 2'd1;
    @(posedge clock);
    #2;
    cpu_valid = 1'b0;
    check("mf_ack_before", {31'h0, cpu_ack}, 32'h1);
    reset = 1'b1;
    #1;
    check("mf_tx_valid_0", {31'h0, tx_valid}, 32'h0);
    check("mf_ack_0", {31'h0, cpu_ack}, 32'h0);
    check("mf_rdata_0", cpu_rdata, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    bus_read(2'd1, rd);
    check("mf_status", rd, 32'h0000_0010);

`ifdef UART_FIFO_IRQ_EN
    // 6. Interrupts
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd); check("ctrl_rd_1", rd, 32'h1);
    check("irq_idle", {31'h0, irq}, 32'h0);
    rx_byte(8'h77);
    check("irq_lag", {31'h0, irq}, 32'h0);
    @(negedge clock);
    check("irq_rx", {31'h0, irq}, 32'h1);
    bus_read(2'd0, rd); check("irq_data", rd, 32'h77);
    @(negedge clock);
    check("irq_rx_clr", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h2);
    @(negedge clock);
    check("irq_tx", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 32'h0);
    @(negedge clock);
    check("irq_off", {31'h0, irq}, 32'h0);
`else
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, rd); check("ctrl_rd_0", rd, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
